// File: rtl/timer_bcd_down_counter.sv
// Cascadable BCD down-counter timer with load/start/pause control and one-shot done.
// The top digit saturates at TOP_MAX so that TOP_MAX=5 counts seconds in mm:ss chains.
//
// state     | meaning
// IDLE      | loaded or reset, waiting for start
// RUN       | decrementing once per accepted tick
// PAUSED    | count frozen until start
// DONE      | reached zero without wrap, frozen until load
module timer_bcd_down_counter #(
  parameter int DIGITS  = 2,
  parameter int TOP_MAX = 9,
  parameter bit WRAP    = 1'b0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load,
  input  logic [4*DIGITS-1:0] set,
  input  logic                start,
  input  logic                pause,
  input  logic                tick,
  output logic [4*DIGITS-1:0] q_bus,
  output logic                running,
  output logic                done,
  output logic                trigger_next
);

  localparam int W = 4 * DIGITS;
  localparam logic [3:0] TOP_LIM = 4'(TOP_MAX);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_PAUSED = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]   state_q, state_d;
  logic [W-1:0] count_q, count_d;
  logic         done_q, done_d;
  logic         armed_q, armed_d;

  logic [W-1:0] set_clamped;
  logic [W-1:0] full_scale;
  logic [W-1:0] count_dec;
  logic         count_zero;

  always_comb begin : clamp_and_full
    logic [3:0] dig;
    logic [3:0] lim;
    set_clamped = '0;
    full_scale  = '0;
    dig         = '0;
    lim         = '0;
    for (int i = 0; i < DIGITS; i++) begin
      lim = (i == DIGITS - 1) ? TOP_LIM : 4'd9;
      dig = set[4*i +: 4];
      set_clamped[4*i +: 4] = (dig > lim) ? lim : dig;
      full_scale[4*i +: 4]  = lim;
    end
  end

  // Ripple borrow: a zero digit rolls to its maximum and passes the borrow upward.
  always_comb begin : bcd_decrement
    logic       borrow;
    logic [3:0] dig;
    borrow    = 1'b1;
    dig       = '0;
    count_dec = count_q;
    for (int i = 0; i < DIGITS; i++) begin
      dig = count_q[4*i +: 4];
      if (borrow) begin
        if (dig == 4'd0) begin
          count_dec[4*i +: 4] = (i == DIGITS - 1) ? TOP_LIM : 4'd9;
        end else begin
          count_dec[4*i +: 4] = dig - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  assign count_zero = (count_q == '0);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    armed_d = 1'b1;
    // The first edge after reset release only arms the block; inputs are dropped.
    if (!armed_q) begin
      state_d = state_q;
    end else if (load) begin
      count_d = set_clamped;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !count_zero) state_d = ST_RUN;
        end
        ST_PAUSED: begin
          if (start) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (start) begin
            state_d = ST_RUN;
          end else if (pause) begin
            state_d = ST_PAUSED;
          end else if (tick) begin
            if (count_zero) begin
              if (WRAP) begin
                count_d = full_scale;
                done_d  = 1'b1;
              end else begin
                state_d = ST_DONE;
              end
            end else begin
              count_d = count_dec;
              if (!WRAP && (count_dec == '0)) begin
                done_d  = 1'b1;
                state_d = ST_DONE;
              end
            end
          end
        end
        default: begin
          state_d = ST_DONE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
      armed_q <= armed_d;
    end
  end

  assign q_bus        = count_q;
  assign running      = (state_q == ST_RUN);
  assign done         = done_q;
  assign trigger_next = WRAP ? (running & tick & count_zero) : 1'b0;

endmodule

// File: tb/tb_timer_bcd_down_counter.sv
// Directed bench for timer_bcd_down_counter: stop-at-zero and wrapping instances
// share stimulus and are checked every cycle against a decimal-arithmetic model.
module tb_timer_bcd_down_counter;

  localparam int D     = 2;
  localparam int TOPM  = 5;
  localparam int FULL  = 59;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0, start = 1'b0, pause = 1'b0, tick = 1'b0;
  logic [7:0] set = 8'h00;

  logic [7:0] q0, q1;
  logic       run0, run1, done0, done1, trig0, trig1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  timer_bcd_down_counter #(.DIGITS(D), .TOP_MAX(TOPM), .WRAP(1'b0)) u_dut0 (
    .clock(clock), .reset(reset), .load(load), .set(set), .start(start),
    .pause(pause), .tick(tick), .q_bus(q0), .running(run0), .done(done0),
    .trigger_next(trig0)
  );

  timer_bcd_down_counter #(.DIGITS(D), .TOP_MAX(TOPM), .WRAP(1'b1)) u_dut1 (
    .clock(clock), .reset(reset), .load(load), .set(set), .start(start),
    .pause(pause), .tick(tick), .q_bus(q1), .running(run1), .done(done1),
    .trigger_next(trig1)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: the count is a plain decimal integer; the digit limits only matter at load and wrap.
  int m_cnt[2];
  int m_st[2];
  bit m_done[2];
  bit m_armed;
  bit wrapv[2] = '{1'b0, 1'b1};

  function automatic int clamp_val(input logic [7:0] s);
    int v = 0;
    int mul = 1;
    for (int i = 0; i < D; i++) begin
      int dig = int'(s[4*i +: 4]);
      int lim = (i == D - 1) ? TOPM : 9;
      if (dig > lim) dig = lim;
      v += dig * mul;
      mul *= 10;
    end
    return v;
  endfunction

  function automatic logic [7:0] to_bcd(input int n);
    logic [7:0] r = '0;
    int v = n;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int w = 0; w < 2; w++) begin
        m_cnt[w] = 0; m_st[w] = M_IDLE; m_done[w] = 1'b0;
      end
      m_armed = 1'b0;
    end else if (!m_armed) begin
      m_armed = 1'b1;
      for (int w = 0; w < 2; w++) m_done[w] = 1'b0;
    end else begin
      for (int w = 0; w < 2; w++) begin
        m_done[w] = 1'b0;
        if (load) begin
          m_cnt[w] = clamp_val(set);
          m_st[w]  = M_IDLE;
        end else if (m_st[w] == M_IDLE) begin
          if (start && m_cnt[w] != 0) m_st[w] = M_RUN;
        end else if (m_st[w] == M_PAUSED) begin
          if (start) m_st[w] = M_RUN;
        end else if (m_st[w] == M_RUN && !start) begin
          if (pause) m_st[w] = M_PAUSED;
          else if (tick) begin
            if (m_cnt[w] == 0) begin
              if (wrapv[w]) begin m_cnt[w] = FULL; m_done[w] = 1'b1; end
            end else begin
              m_cnt[w] = m_cnt[w] - 1;
              if (m_cnt[w] == 0 && !wrapv[w]) begin m_done[w] = 1'b1; m_st[w] = M_DONE; end
            end
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    chk("q_bus0",   {8'h00, q0}, {8'h00, to_bcd(m_cnt[0])});
    chk("running0", {15'd0, run0}, {15'd0, m_st[0] == M_RUN});
    chk("done0",    {15'd0, done0}, {15'd0, m_done[0]});
    chk("trig0",    {15'd0, trig0}, 16'd0);
    chk("q_bus1",   {8'h00, q1}, {8'h00, to_bcd(m_cnt[1])});
    chk("running1", {15'd0, run1}, {15'd0, m_st[1] == M_RUN});
    chk("done1",    {15'd0, done1}, {15'd0, m_done[1]});
    chk("trig1",    {15'd0, trig1}, {15'd0, (m_st[1] == M_RUN) && tick && (m_cnt[1] == 0)});
  end

  task automatic apply(input logic l, input logic [7:0] s, input logic st,
                       input logic p, input logic t);
    load = l; set = s; start = st; pause = p; tick = t;
    @(posedge clock);
    #1;
    load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
  endtask

  logic [7:0] exp_down[10] = '{8'h09, 8'h08, 8'h07, 8'h06, 8'h05,
                               8'h04, 8'h03, 8'h02, 8'h01, 8'h00};

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("lit_rst_q", {8'h00, q0}, 16'h0000);
    chk("lit_rst_run", {15'd0, run0}, 16'd0);
    reset = 1'b0;
    apply(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    chk("lit_arm_ignore", {8'h00, q0}, 16'h0000);

    // Load 10, count down to zero.
    apply(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
    chk("lit_load10", {8'h00, q0}, 16'h0010);
    apply(1'b0, 8'h10, 1'b1, 1'b0, 1'b0);
    chk("lit_run_start", {15'd0, run0}, 16'd1);
    for (int k = 0; k < 10; k++) begin
      apply(1'b0, 8'h10, 1'b0, 1'b0, 1'b1);
      chk("lit_down_q", {8'h00, q0}, {8'h00, exp_down[k]});
      chk("lit_down_done", {15'd0, done0}, (k == 9) ? 16'd1 : 16'd0);
    end
    chk("lit_done_run0", {15'd0, run0}, 16'd0);
    chk("lit_wrap_at0", {8'h00, q1}, 16'h0000);
    chk("lit_wrap_run", {15'd0, run1}, 16'd1);
    apply(1'b0, 8'h10, 1'b0, 1'b0, 1'b1);
    chk("lit_wrap59", {8'h00, q1}, 16'h0059);
    chk("lit_wrap_done", {15'd0, done1}, 16'd1);
    chk("lit_stop_hold", {8'h00, q0}, 16'h0000);
    apply(1'b0, 8'h10, 1'b1, 1'b0, 1'b0);
    chk("lit_done_start_ign", {15'd0, run0}, 16'd0);

    // Zero load: start must not run.
    apply(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("lit_zero_q", {8'h00, q0}, 16'h0000);
      chk("lit_zero_done", {15'd0, done0}, 16'd0);
    end
    chk("lit_zero_run1", {15'd0, run1}, 16'd0);

    // Wrap through zero.
    apply(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 8'h01, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 8'h01, 1'b0, 1'b0, 1'b1);
    chk("lit_w_00", {8'h00, q1}, 16'h0000);
    chk("lit_w_nodone", {15'd0, done1}, 16'd0);
    chk("lit_s_done", {15'd0, done0}, 16'd1);
    tick = 1'b1;
    #1;
    chk("lit_trig1", {15'd0, trig1}, 16'd1);
    chk("lit_trig0", {15'd0, trig0}, 16'd0);
    @(posedge clock);
    #1;
    tick = 1'b0;
    chk("lit_w_59", {8'h00, q1}, 16'h0059);
    chk("lit_w_done", {15'd0, done1}, 16'd1);
    #1;
    chk("lit_trig1_low", {15'd0, trig1}, 16'd0);
    apply(1'b0, 8'h01, 1'b0, 1'b0, 1'b1);
    chk("lit_w_58", {8'h00, q1}, 16'h0058);
    chk("lit_w_done_low", {15'd0, done1}, 16'd0);

    // Load clamping.
    apply(1'b1, 8'hFC, 1'b0, 1'b0, 1'b0);
    chk("lit_clamp_FC", {8'h00, q0}, 16'h0059);
    chk("lit_clamp_FC1", {8'h00, q1}, 16'h0059);
    apply(1'b1, 8'h7A, 1'b0, 1'b0, 1'b0);
    chk("lit_clamp_7A", {8'h00, q0}, 16'h0059);
    apply(1'b1, 8'h0B, 1'b0, 1'b0, 1'b0);
    chk("lit_clamp_0B", {8'h00, q0}, 16'h0009);
    apply(1'b1, 8'h4F, 1'b0, 1'b0, 1'b0);
    chk("lit_clamp_4F", {8'h00, q0}, 16'h0049);

    // Pause/resume and same-cycle priority.
    apply(1'b1, 8'h30, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 8'h30, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 8'h30, 1'b0, 1'b1, 1'b1);
    chk("lit_pause_q", {8'h00, q0}, 16'h0030);
    chk("lit_pause_run", {15'd0, run0}, 16'd0);
    apply(1'b0, 8'h30, 1'b0, 1'b0, 1'b1);
    chk("lit_paused_hold", {8'h00, q0}, 16'h0030);
    apply(1'b0, 8'h30, 1'b1, 1'b0, 1'b0);
    chk("lit_resume", {15'd0, run0}, 16'd1);
    apply(1'b0, 8'h30, 1'b0, 1'b0, 1'b1);
    chk("lit_29", {8'h00, q0}, 16'h0029);
    apply(1'b1, 8'h12, 1'b0, 1'b0, 1'b1);
    chk("lit_load_wins", {8'h00, q0}, 16'h0012);
    chk("lit_load_idle", {15'd0, run0}, 16'd0);

    // Asynchronous reset mid-count.
    apply(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 8'h42, 1'b1, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("lit_async_q", {8'h00, q0}, 16'h0000);
    chk("lit_async_run", {15'd0, run0}, 16'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 8'h42, 1'b0, 1'b0, 1'b1);
      chk("lit_post_rst_q", {8'h00, q0}, 16'h0000);
    end
    apply(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 8'h42, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 8'h42, 1'b0, 1'b0, 1'b1);
    chk("lit_resume_41", {8'h00, q0}, 16'h0041);

    repeat (2) @(posedge clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/timer_bcd_down_counter.md
TIMER_BCD_DOWN_COUNTER -- requirements
Module: timer_bcd_down_counter

Interface
REQ-001 SHALL provide parameter DIGITS, default 2: number of cascaded BCD digits, legal range 1..4.
REQ-002 SHALL provide parameter TOP_MAX, default 9: maximum value of the most-significant digit, legal range 1..9 (5 gives mm:ss-style seconds).
REQ-003 SHALL provide parameter WRAP, default 0: 1 = reload to full-scale after zero; 0 = stop at zero.
REQ-004 SHALL provide port clock, input, 1 bit: single clock, rising-edge.
REQ-005 SHALL provide port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL provide port load, input, 1 bit: synchronous preset strobe.
REQ-007 SHALL provide port set, input, 4*DIGITS bits: BCD preset value, digit 0 in bits [3:0].
REQ-008 SHALL provide port start, input, 1 bit: begin or resume counting.
REQ-009 SHALL provide port pause, input, 1 bit: suspend counting.
REQ-010 SHALL provide port tick, input, 1 bit: count-enable strobe, one decrement per high cycle.
REQ-011 SHALL provide port q_bus, output, 4*DIGITS bits: current BCD count, registered.
REQ-012 SHALL provide port running, output, 1 bit: high in state RUN.
REQ-013 SHALL provide port done, output, 1 bit: registered one-cycle pulse on reaching zero.
REQ-014 SHALL provide port trigger_next, output, 1 bit: combinational borrow to the next cascaded stage.

Function
REQ-015 SHALL implement states IDLE, RUN, PAUSED and DONE in a registered FSM.
REQ-016 SHALL, in any state, on load=1, capture set into q_bus at the next edge and enter IDLE.
REQ-017 SHALL clamp any loaded digit above 9 to 9, and a top digit above TOP_MAX to TOP_MAX.
REQ-018 SHALL apply input priority load > start > pause > tick within a cycle.
REQ-019 SHALL move IDLE->RUN on start=1 when q_bus!=0; start=1 with q_bus=0 SHALL stay in IDLE and leave done=0.
REQ-020 SHALL move RUN->PAUSED on pause=1, ignoring tick that cycle.
REQ-021 SHALL move PAUSED->RUN on start=1; PAUSED SHALL hold q_bus.
REQ-022 SHALL, in RUN with tick=1, decrement q_bus by one in BCD at the next edge (latency 1 cycle).
REQ-023 SHALL, per digit, go 0->9 with a borrow to the next digit, except the top digit, which goes 0->TOP_MAX.
REQ-024 SHALL leave q_bus unchanged whenever tick=0 or the state is not RUN.
REQ-025 SHALL, when q_bus=1 and a tick is accepted in RUN with WRAP=0: set q_bus to 0, pulse done for one cycle, and enter DONE.
REQ-026 SHALL, when q_bus=0 and a tick is accepted in RUN with WRAP=1: reload q_bus to full-scale (TOP_MAX then all 9s), stay in RUN, and pulse done for one cycle.
REQ-027 SHALL, with WRAP=1, pulse done on the zero->full-scale reload only, not on reaching 0.
REQ-028 SHALL hold DONE, with q_bus=0, until load or reset; start in DONE SHALL be ignored.
REQ-029 SHALL drive trigger_next = running AND tick AND (q_bus==0) combinationally, so that N instances cascade by wiring trigger_next to the next instance's tick.
REQ-030 SHALL keep trigger_next at 0 when WRAP=0.
REQ-031 SHALL never let q_bus hold a non-BCD digit, or a top digit above TOP_MAX.

Reset
REQ-032 SHALL, while reset=1, asynchronously force state IDLE, q_bus=0, running=0 and done=0, independent of clock.
REQ-033 SHALL, on reset asserted mid-count, discard the count; after release the block SHALL require load and start before counting resumes.
REQ-034 SHALL ignore all inputs on the first clock edge coincident with reset deassertion.

Verification
REQ-035 SHALL be verified with DIGITS=2, TOP_MAX=5, WRAP=0: load 0x10, start, 10 ticks -> q_bus 09,08,...,00; done pulses once on the 10th tick; state DONE, running=0.
REQ-036 SHALL be verified with the same parameters: load 0x00, start, 5 ticks -> q_bus stays 00, running=0, done never pulses.
REQ-037 SHALL be verified with DIGITS=2, TOP_MAX=5, WRAP=1: load 0x01, start, 3 ticks -> 00, 59, 58; done pulses on the 00->59 tick; trigger_next=1 in that cycle only.
REQ-038 SHALL be verified on load clamping: load 0xFC -> q_bus=0x59.
REQ-039 SHALL be verified on pause/resume and same-cycle priority: in RUN at 0x30, assert pause with tick -> q_bus holds 30; start then tick -> 29; load and tick in the same cycle -> loaded value, state IDLE.
REQ-040 SHALL be verified on reset: assert reset between clock edges during RUN at 0x42 -> q_bus=00 and running=0 immediately; after release, ticks -> no change.
